patch_table: RTL
================

# patch_table

Parametrised successor to the single-CAM patch store. It holds NUM_PATCHES address/mask match entries in registers and compares them in parallel against each RAM burst address, using a fixed-priority encoder. Each entry has a per-patch enable, a content-buffer offset and a word-length limit. The block sits between the config bus and the RAM emulation path: it triggers patches and streams replacement words from a block-RAM content buffer.

## Interface
- ADDR_WIDTH, 23: burst address width (≤ 32).
- DATA_WIDTH, 16: patch word width (≤ 16, config-bus width).
- NUM_PATCHES, 8: match entries (1–32).
- CONTENT_AW, 13: content buffer address bits (depth 2^CONTENT_AW, ≤ 15).

- mclk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- config_addr  in  16  config bus address.
- config_data  in  16  config bus write data.
- config_strobe  in  1  one-cycle config write.
- burst_addr  in  ADDR_WIDTH  RAM burst start address.
- burst_addr_strobe  in  1  burst_addr valid this cycle.
- patch_trigger  out  1  one-cycle pulse: burst matched an enabled entry.
- patch_active  out  1  level: patch stream in progress.
- patch_index  out  5  index of the matched entry; held until the next match.
- patch_data  out  DATA_WIDTH  current replacement word.
- patch_data_next  in  1  advance to the next word.

## Operation
- **Register map.** Entry registers are at 0x7000 + 8·i + f, for i < NUM_PATCHES:
  - f0 addr[15:0]
  - f1 addr[ADDR_WIDTH-1:16]
  - f2 mask[15:0]
  - f3 mask high
  - f4 offset[CONTENT_AW-1:0]
  - f5 length (words; 0 = unlimited)
  - f6 control (bit0 enable)
  - f7 reserved, ignored
- **Unmapped writes.** Writes to entries ≥ NUM_PATCHES are ignored.
- **Content buffer.** The buffer is at 0x8000 + a, for a < 2^CONTENT_AW, and stores config_data[DATA_WIDTH-1:0]. Writes are registered and commit one cycle after the strobe.
- **Match rule.** Entry i matches when enable_i && ((burst_addr ^ addr_i) & ~mask_i) == 0. Mask bit 1 means don't-care.
- **Priority.** The lowest matching index wins.
- **Start address.** On a match, the start address is (offset_i + burst_addr[CONTENT_AW-1:0]) mod 2^CONTENT_AW, and remaining is set to length_i.
- **Stream states.** The stream FSM has two states, IDLE and STREAM.
  - A match in either state loads the entry, pulses patch_trigger and enters STREAM. A new match aborts the current stream.
  - In STREAM, patch_data_next increments the read address (wrapping modulo depth). If length ≠ 0 it also decrements remaining. When remaining goes 1→0, the FSM returns to IDLE.
  - In IDLE, patch_data_next is ignored and patch_data holds its last value.
- **No match.** A strobe with no match changes nothing: an active stream continues and no trigger is produced.
- **Reset values.** All outputs are 0. All entries are cleared, including every enable bit. FSM = IDLE. Content RAM is not cleared.

## Timing
- **Pipeline.**
  - S1 (strobe +1): burst_addr and strobe registered.
  - S2 (+2): match vector registered.
  - S3 (+3): priority encode; patch_trigger, patch_index and patch_active update.
  - S4 (+4): content read address loaded.
  - S5 (+5): patch_data valid.
- **Latency.** Trigger latency is 3 mclk; first data is valid 5 mclk after burst_addr_strobe.
- **Advance.** patch_data_next at cycle n yields the next word on patch_data at n+2 (address at n+1, RAM at n+2).
  - patch_data_next in the same cycle as an S4 load is ignored; the load wins.
- **Back-to-back strobes.** Strobes on consecutive cycles are each evaluated. The last match wins at S4.
- **Config sampling.** Entry registers are sampled at S2 for the match decision and at S3 for offset/length. A config write landing between those stages may mix old and new values; software disables the entry (f6) first.
- **Read-during-write.** A content read and write to the same address in the same cycle returns the old data.
- **Reset mid-stream.** patch_active and patch_trigger drop immediately (asynchronous). No pipeline stage survives reset.

## Test plan
- **Basic match.** Entry 0: addr 0x001000, mask 0x0000FF, offset 0x0100, length 0, enable 1. Content 0x8100..0x8103 = A0..A3. Strobe burst_addr 0x001002. Required: trigger at +3; patch_data = A2 at +5; A3 after one patch_data_next.
- **Priority and disable.**
  - Entries 2 and 5 both match 0x400000. Required: patch_index = 2.
  - Clear entry 2 enable, strobe again. Required: patch_index = 5.
  - Clear entry 5 enable. Required: no trigger.
- **Length limit.** Length 3. Issue 5 patch_data_next pulses. Required: patch_active falls after the 3rd pulse; patch_data then holds its last value.
- **Wrap-around.** Offset 0x1FFE, burst_addr[12:0] = 1 (CONTENT_AW = 13). Required: words are read from 0x1FFF, 0x0000, 0x0001.
- **Abort and reset.**
  - Strobe a new matching address mid-stream. Required: a new trigger pulse and a new start address.
  - Strobe a non-matching address mid-stream. Required: the stream continues unchanged.
  - Assert reset mid-stream. Required: all outputs are 0 in the same cycle, and entries are disabled afterwards.

Source files
------------

// File: rtl/patch_table.sv
// patch_table: NUM_PATCHES address/mask entries matched in parallel against each
// burst address; the lowest matching entry streams words from a block-RAM buffer.
module patch_table #(
    parameter int ADDR_WIDTH  = 23,
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_PATCHES = 8,
    parameter int CONTENT_AW  = 13
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic [15:0]           config_addr,
    input  logic [15:0]           config_data,
    input  logic                  config_strobe,
    input  logic [ADDR_WIDTH-1:0] burst_addr,
    input  logic                  burst_addr_strobe,
    output logic                  patch_trigger,
    output logic                  patch_active,
    output logic [4:0]            patch_index,
    output logic [DATA_WIDTH-1:0] patch_data,
    input  logic                  patch_data_next
);
    typedef enum logic {IDLE, STREAM} state_t;

    localparam int DEPTH = 2 ** CONTENT_AW;
    localparam logic [ADDR_WIDTH-1:0] LO_HALF = ADDR_WIDTH'(32'h0000_FFFF);

    // ---------------- config bus decode ----------------
    logic       entry_wr;
    logic       content_wr;
    logic [8:0] entry_sel;
    logic [2:0] field_sel;

    always_comb begin
        entry_wr   = config_strobe && (config_addr[15:12] == 4'h7);
        entry_sel  = config_addr[11:3];
        field_sel  = config_addr[2:0];
        content_wr = config_strobe && config_addr[15] &&
                     ((config_addr[14:0] >> CONTENT_AW) == 15'd0);
    end

    // ---------------- pipeline / stream state ----------------
    logic                   s1_vld_q, s1_vld_d;
    logic [ADDR_WIDTH-1:0]  s1_addr_q, s1_addr_d;
    logic [NUM_PATCHES-1:0] match_q, match_d;
    logic [CONTENT_AW-1:0]  s2_lo_q, s2_lo_d;
    logic                   trigger_q, trigger_d;
    logic [4:0]             index_q, index_d;
    state_t                 state_q, state_d;
    logic [15:0]            remaining_q, remaining_d;
    logic [CONTENT_AW-1:0]  start_q, start_d;
    logic                   load_q, load_d;
    logic [CONTENT_AW-1:0]  rd_addr_q, rd_addr_d;
    logic                   rd_en_q, rd_en_d;
    logic                   data_ok_q, data_ok_d;
    logic                   wr_en_q, wr_en_d;
    logic [CONTENT_AW-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;

    logic [CONTENT_AW-1:0]  offset_w [NUM_PATCHES];
    logic [15:0]            length_w [NUM_PATCHES];

    // ---------------- match entries ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PATCHES; gi++) begin : g_entry
            logic [ADDR_WIDTH-1:0] addr_q, addr_d;
            logic [ADDR_WIDTH-1:0] mask_q, mask_d;
            logic [CONTENT_AW-1:0] offset_q, offset_d;
            logic [15:0]           length_q, length_d;
            logic                  enable_q, enable_d;

            always_comb begin
                addr_d   = addr_q;
                mask_d   = mask_q;
                offset_d = offset_q;
                length_d = length_q;
                enable_d = enable_q;
                if (entry_wr && (entry_sel == 9'(gi))) begin
                    case (field_sel)
                        3'd0: addr_d   = (addr_q & ~LO_HALF) | ADDR_WIDTH'(config_data);
                        3'd1: addr_d   = (addr_q & LO_HALF) | ADDR_WIDTH'({config_data, 16'h0000});
                        3'd2: mask_d   = (mask_q & ~LO_HALF) | ADDR_WIDTH'(config_data);
                        3'd3: mask_d   = (mask_q & LO_HALF) | ADDR_WIDTH'({config_data, 16'h0000});
                        3'd4: offset_d = CONTENT_AW'(config_data);
                        3'd5: length_d = config_data;
                        3'd6: enable_d = config_data[0];
                        default: ;
                    endcase
                end
            end

            always_ff @(posedge mclk or posedge reset) begin
                if (reset) begin
                    addr_q   <= '0;
                    mask_q   <= '0;
                    offset_q <= '0;
                    length_q <= '0;
                    enable_q <= 1'b0;
                end else begin
                    addr_q   <= addr_d;
                    mask_q   <= mask_d;
                    offset_q <= offset_d;
                    length_q <= length_d;
                    enable_q <= enable_d;
                end
            end

            // Mask bit set means the address bit is a don't-care.
            assign match_d[gi]  = s1_vld_q && enable_q &&
                                  (((s1_addr_q ^ addr_q) & ~mask_q) == '0);
            assign offset_w[gi] = offset_q;
            assign length_w[gi] = length_q;
        end
    endgenerate

    // ---------------- priority encoder (lowest index wins) ----------------
    logic                  hit;
    logic [4:0]            hit_idx;
    logic [CONTENT_AW-1:0] hit_off;
    logic [15:0]           hit_len;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        hit_len = '0;
        for (int i = NUM_PATCHES - 1; i >= 0; i--) begin
            if (match_q[i]) begin
                hit     = 1'b1;
                hit_idx = 5'(i);
                hit_off = offset_w[i];
                hit_len = length_w[i];
            end
        end
    end

    always_comb begin
        s1_vld_d  = burst_addr_strobe;
        s1_addr_d = burst_addr;
        s2_lo_d   = s1_addr_q[CONTENT_AW-1:0];
        wr_en_d   = content_wr;
        wr_addr_d = config_addr[CONTENT_AW-1:0];
        wr_data_d = config_data[DATA_WIDTH-1:0];
        data_ok_d = data_ok_q | rd_en_q;
    end

    // ---------------- stream FSM ----------------
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        start_d     = start_q;
        load_d      = 1'b0;
        trigger_d   = 1'b0;
        index_d     = index_q;
        rd_addr_d   = rd_addr_q;
        rd_en_d     = 1'b0;

        if (hit) begin
            trigger_d   = 1'b1;
            index_d     = hit_idx;
            state_d     = STREAM;
            remaining_d = hit_len;
            start_d     = hit_off + s2_lo_q;
            load_d      = 1'b1;
        end

        // A pending start-address load takes precedence over an advance request.
        if (load_q) begin
            rd_addr_d = start_q;
            rd_en_d   = 1'b1;
        end else if ((state_q == STREAM) && patch_data_next && !hit) begin
            rd_addr_d = rd_addr_q + CONTENT_AW'(1);
            rd_en_d   = 1'b1;
            // remaining == 0 while streaming means the entry has no length limit.
            if (remaining_q != 16'd0) begin
                remaining_d = remaining_q - 16'd1;
                if (remaining_q == 16'd1) begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            s1_vld_q    <= 1'b0;
            s1_addr_q   <= '0;
            match_q     <= '0;
            s2_lo_q     <= '0;
            trigger_q   <= 1'b0;
            index_q     <= '0;
            state_q     <= IDLE;
            remaining_q <= '0;
            start_q     <= '0;
            load_q      <= 1'b0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            data_ok_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_addr_q   <= s1_addr_d;
            match_q     <= match_d;
            s2_lo_q     <= s2_lo_d;
            trigger_q   <= trigger_d;
            index_q     <= index_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            start_q     <= start_d;
            load_q      <= load_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            data_ok_q   <= data_ok_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // ---------------- content buffer ----------------
    // Reads are enabled only on load/advance so patch_data holds while idle.
    logic [DATA_WIDTH-1:0] content_mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_dout_q;

    always_ff @(posedge mclk) begin
        if (wr_en_q) begin
            content_mem[wr_addr_q] <= wr_data_q;
        end
        if (rd_en_q) begin
            ram_dout_q <= content_mem[rd_addr_q];
        end
    end

    assign patch_trigger = trigger_q;
    assign patch_active  = (state_q == STREAM);
    assign patch_index   = index_q;
    assign patch_data    = data_ok_q ? ram_dout_q : '0;

endmodule
